dcache_mem_ctrl: RTL and testbench
==================================

# dcache_mem_ctrl

Block-transfer engine between the data cache and the byte-wide main RAM port. Accepts one miss request from the data cache at a time: a block fill (read) or a dirty-block write-back. Serialises it into 16 single-byte RAM accesses and returns the assembled block with a one-cycle valid pulse, or acknowledges the write-back. Sits directly downstream of the data cache. IO-mapped addresses never reach it; the cache does not raise misses for them.

## Interface

- BLOCK_WIDTH, 4, log2 of block size in bytes
- BLOCK_SIZE, 2**BLOCK_WIDTH, block size in bytes (16)

- clkIn  input  1  system clock
- resetIn  input  1  asynchronous, active-low reset
- readyIn  input  1  global enable; low = freeze
- missIn  input  1  cache miss request (level, held by cache until served)
- missAddrIn  input  [31:BLOCK_WIDTH]  block address of request
- readWriteIn  input  1  1 = fill (read), 0 = write-back
- writeBackIn  input  [BLOCK_SIZE*8-1:0]  block data for write-back
- memDataValid  output  1  fill complete pulse
- memAddr  output  [31:BLOCK_WIDTH]  block address of current/finished transfer
- memDataOut  output  [BLOCK_SIZE*8-1:0]  assembled fill block
- acceptWrite  output  1  write-back accepted pulse (cache clears dirty bit of memAddr line)
- ramDataIn  input  8  RAM read data (1-cycle latency)
- ramDataOut  output  8  RAM write data
- ramAddr  output  32  RAM byte address
- ramWrite  output  1  RAM write enable (1 = write, 0 = read)

## Operation

- States: IDLE, READ, WRITE, DONE. Byte counter cnt, 5 bits.
- IDLE: if missIn && readyIn, latch missAddrIn into memAddr, and writeBackIn into a data buffer; cnt <= 0. Next state is READ if readWriteIn = 1, else WRITE. missIn in any other state is ignored.
- Base byte address = {memAddr, BLOCK_WIDTH'b0}. Little-endian: byte k is at base+k and occupies bits [8k+7:8k].
- READ: ramWrite = 0, ramAddr = base + cnt while cnt < 16. The byte on ramDataIn in a READ cycle with cnt ≥ 1 is byte cnt-1 and is stored into memDataOut[8(cnt-1)+7 : 8(cnt-1)]. cnt increments each cycle. Leave to DONE after the cycle with cnt = 16; in that cycle ramAddr is don't-care and ramWrite = 0.
- DONE: memDataValid = 1 for exactly this cycle. memAddr and memDataOut hold the filled block. Next state is IDLE.
- WRITE: ramWrite = 1, ramAddr = base + cnt, ramDataOut = buffer byte cnt, for cnt 0..15. Go to IDLE after cnt = 15.
- acceptWrite = 1 in the first WRITE cycle only (cnt = 0), with memAddr = written block. The buffer is a snapshot, so a store hitting that line after acceptance re-dirties it correctly.
- readyIn low: no state, counter, buffer or output-register change. ramWrite is forced 0. memDataValid and acceptWrite are forced 0 and re-emitted once readyIn returns.
- Outstanding transfers are never aborted; branch-misprediction clears do not reach this block.

## Timing

- Reset (resetIn = 0, asynchronous) has immediate effect: state IDLE, cnt 0, and every output is 0 (memDataValid, memAddr, memDataOut, acceptWrite, ramDataOut, ramAddr, ramWrite).
- Reset mid-WRITE leaves RAM partially updated; this is accepted. Reset mid-READ produces no memDataValid.
- IDLE outputs: ramWrite 0, ramAddr 0, ramDataOut 0, pulses 0. memAddr and memDataOut hold their last value.
- Request sampled at edge of cycle A (IDLE, missIn = 1).
- Fill: READ occupies A+1..A+17. memDataValid is high in A+18. IDLE is reached in A+19; a new miss can be sampled then. Fill latency = 18 cycles from sample to valid.
- Write-back: WRITE occupies A+1..A+16 with acceptWrite in A+1. IDLE is reached in A+17.
- The cache updates its line at the DONE edge. The cycle after DONE is IDLE, so the stale miss is gone before re-sampling; there is no duplicate fill.
- ramAddr arithmetic is 32-bit. The base never carries out of the block; the low BLOCK_WIDTH bits equal cnt.

## Test plan

- Fill: miss at block 0x00001 (base 0x10), readWriteIn = 1, RAM bytes 0x10..0x1F = 0xA0..0xAF. Required: ramAddr steps 0x10..0x1F; memDataValid pulses exactly 18 cycles after sample; memDataOut = 0xAFAE…A1A0; memAddr = 0x00001.
- Write-back: block 0x00F02 with data bytes k = k+0x30, readWriteIn = 0. Required: acceptWrite is a single pulse in the first WRITE cycle with memAddr = 0x00F02; 16 consecutive ramWrite = 1 cycles at 0xF020..0xF02F with data 0x30..0x3F; IDLE at A+17.
- Back-to-back: write-back request then a fill request held asserted. Required: the fill is sampled only in the first IDLE cycle after WRITE; no overlap of ramWrite and read addresses.
- Stall: readyIn = 0 for 5 cycles at cnt = 7 of a fill. Required: ramAddr frozen at base+7; memDataValid delayed by exactly 5 cycles; data is still correct.
- Reset mid-write-back at cnt = 9. Required: all outputs 0 immediately; no further ramWrite; a new fill after reset completes normally.
- Miss while busy: change missAddrIn and readWriteIn during READ. Required: the transfer continues with the latched address, and the change is ignored until IDLE.

Source files
------------

// File: rtl/dcache_mem_ctrl.sv
// Block-transfer engine serialising cache fills/write-backs into 16 byte-wide RAM accesses.
// Fill: 18 cycles sample-to-valid; write-back: 16 write cycles. readyIn low freezes all state and masks pulses/ramWrite.
module dcache_mem_ctrl #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    readyIn,
  input  logic                    missIn,
  input  logic [31:BLOCK_WIDTH]   missAddrIn,
  input  logic                    readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
  output logic                    memDataValid,
  output logic [31:BLOCK_WIDTH]   memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    acceptWrite,
  input  logic [7:0]              ramDataIn,
  output logic [7:0]              ramDataOut,
  output logic [31:0]             ramAddr,
  output logic                    ramWrite
);

  localparam int CW = BLOCK_WIDTH + 1;
  localparam int DW = BLOCK_SIZE * 8;
  localparam logic [CW-1:0] CNT_LAST_WR = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0] CNT_LAST_RD = CW'(BLOCK_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:BLOCK_WIDTH]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]           mem_data_q, mem_data_d;
  logic [DW-1:0]           wb_buf_q, wb_buf_d;

  logic [CW-1:0]           cnt_m1;
  logic [BLOCK_WIDTH-1:0]  wr_idx;
  logic [BLOCK_WIDTH-1:0]  rd_idx;
  logic [31:0]             base_addr;
  logic [31:0]             byte_addr;

  assign cnt_m1    = cnt_q - CW'(1);
  assign wr_idx    = cnt_q[BLOCK_WIDTH-1:0];
  // Read data arrives one cycle after its address, so it belongs to the previous byte slot.
  assign rd_idx    = cnt_m1[BLOCK_WIDTH-1:0];
  assign base_addr = {mem_addr_q, {BLOCK_WIDTH{1'b0}}};
  assign byte_addr = base_addr + {{(32-BLOCK_WIDTH){1'b0}}, wr_idx};

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wb_buf_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wb_buf_q   <= wb_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wb_buf_d   = wb_buf_q;
    if (readyIn) begin
      case (state_q)
        S_IDLE: begin
          if (missIn) begin
            mem_addr_d = missAddrIn;
            wb_buf_d   = writeBackIn;
            cnt_d      = '0;
            state_d    = readWriteIn ? S_READ : S_WRITE;
          end
        end
        S_READ: begin
          if (cnt_q != '0) begin
            mem_data_d[{rd_idx, 3'b000} +: 8] = ramDataIn;
          end
          if (cnt_q == CNT_LAST_RD) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (cnt_q == CNT_LAST_WR) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    memDataValid = 1'b0;
    acceptWrite  = 1'b0;
    ramWrite     = 1'b0;
    ramAddr      = '0;
    ramDataOut   = '0;
    case (state_q)
      S_READ: begin
        if (!cnt_q[BLOCK_WIDTH]) ramAddr = byte_addr;
      end
      S_WRITE: begin
        ramWrite    = readyIn;
        ramAddr     = byte_addr;
        ramDataOut  = wb_buf_q[{wr_idx, 3'b000} +: 8];
        acceptWrite = readyIn && (cnt_q == '0);
      end
      S_DONE: memDataValid = readyIn;
      default: ;
    endcase
  end

  assign memAddr    = mem_addr_q;
  assign memDataOut = mem_data_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: transaction-level model checked every cycle plus literal expectations per scenario.
module tb_dcache_mem_ctrl;

  logic         clkIn = 1'b0;
  logic         resetIn, readyIn, missIn, readWriteIn;
  logic [31:4]  missAddrIn;
  logic [127:0] writeBackIn;
  logic         memDataValid, acceptWrite, ramWrite;
  logic [31:4]  memAddr;
  logic [127:0] memDataOut;
  logic [7:0]   ramDataIn, ramDataOut;
  logic [31:0]  ramAddr;

  int cyc = 0;
  int wr_cnt = 0;
  int total = 0;
  int passes = 0;

  dcache_mem_ctrl dut (
    .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .missIn(missIn),
    .missAddrIn(missAddrIn), .readWriteIn(readWriteIn), .writeBackIn(writeBackIn),
    .memDataValid(memDataValid), .memAddr(memAddr), .memDataOut(memDataOut),
    .acceptWrite(acceptWrite), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
    .ramAddr(ramAddr), .ramWrite(ramWrite)
  );

  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc <= cyc + 1;
  always @(negedge clkIn) if (ramWrite) wr_cnt <= wr_cnt + 1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return (a >= 16'h0010 && a <= 16'h001F) ? a[7:0] + 8'h90 : a[7:0];
  endfunction

  // Environment RAM: 1-cycle read latency, frozen together with the rest of the system.
  logic [7:0] wmem [0:65535];
  bit         wvld [0:65535];
  logic [7:0] ram_rd = 8'h00;
  assign ramDataIn = ram_rd;

  always @(posedge clkIn) begin
    if (readyIn) begin
      if (ramWrite) begin
        wmem[ramAddr[15:0]] <= ramDataOut;
        wvld[ramAddr[15:0]] <= 1'b1;
      end
      ram_rd <= wvld[ramAddr[15:0]] ? wmem[ramAddr[15:0]] : init_byte(ramAddr[15:0]);
    end
  end

  function automatic logic [7:0] env_byte(input logic [15:0] a);
    return wvld[a] ? wmem[a] : init_byte(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passes++;
  endtask

  // Transaction model: kind 0 idle, 1 fill, 2 write-back; k = enabled cycles since the request was sampled.
  int           m_kind = 0;
  int           m_k = 0;
  logic [27:0]  m_addr = '0;
  logic [127:0] m_buf = '0;
  logic [127:0] m_dout = '0;
  logic [7:0]   m_mem [0:65535];
  bit           m_vld [0:65535];

  function automatic logic [127:0] model_block(input logic [27:0] blk);
    logic [127:0] r;
    logic [15:0]  a;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      a = 16'({blk, 4'h0} + j);
      r[8*j +: 8] = m_vld[a] ? m_mem[a] : init_byte(a);
    end
    return r;
  endfunction

  always @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      m_kind = 0; m_k = 0; m_addr = '0; m_dout = '0;
    end else if (readyIn) begin
      if (m_kind == 0) begin
        if (missIn) begin
          m_kind = readWriteIn ? 1 : 2;
          m_k    = 1;
          m_addr = missAddrIn;
          m_buf  = writeBackIn;
        end
      end else if (m_kind == 1) begin
        if (m_k == 18) m_kind = 0;
        else begin
          m_k++;
          if (m_k == 18) m_dout = model_block(m_addr);
        end
      end else begin
        m_mem[16'({m_addr, 4'h0} + m_k - 1)] = m_buf[8*(m_k-1) +: 8];
        m_vld[16'({m_addr, 4'h0} + m_k - 1)] = 1'b1;
        if (m_k == 16) m_kind = 0;
        else m_k++;
      end
    end
  end

  always @(negedge clkIn) begin
    logic [31:0] base;
    if (resetIn) begin
      base = {m_addr, 4'h0};
      chk("memAddr", memAddr, m_addr);
      if (!(m_kind == 1 && m_k < 18)) chk("memDataOut", memDataOut, m_dout);
      chk("memDataValid", memDataValid, (m_kind == 1 && m_k == 18 && readyIn));
      chk("acceptWrite", acceptWrite, (m_kind == 2 && m_k == 1 && readyIn));
      chk("ramWrite", ramWrite, (m_kind == 2 && readyIn));
      if (m_kind == 0) chk("ramAddr", ramAddr, 0);
      else if (m_kind == 2 || m_k <= 16) chk("ramAddr", ramAddr, base + m_k - 1);
      else if (m_k == 18) chk("ramAddr", ramAddr, 0);
      if (m_kind == 0) chk("ramDataOut", ramDataOut, 0);
      else if (m_kind == 2) chk("ramDataOut", ramDataOut, m_buf[8*(m_k-1) +: 8]);
    end
  end

  // Must be called just after a rising edge; waits for the served pulse, then drops missIn.
  task automatic do_req(input logic [27:0] a, input logic rw, input logic [127:0] wd,
                        input int st_at, input int st_len, input int chg_at,
                        output int lat, output logic [27:0] am, output logic [31:0] saddr);
    int c0;
    bit seen;
    missAddrIn = a; readWriteIn = rw; writeBackIn = wd; missIn = 1'b1;
    c0 = cyc; seen = 0; lat = -1; am = '0; saddr = '0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clkIn);
      if (!readyIn) saddr = ramAddr;
      if (rw ? memDataValid : acceptWrite) begin
        seen = 1; lat = cyc - c0; am = memAddr;
      end
      @(posedge clkIn); #1;
      readyIn = !(cyc - c0 >= st_at && cyc - c0 < st_at + st_len);
      if (cyc - c0 == chg_at) begin
        missAddrIn = 28'hABCDE; readWriteIn = ~rw;
      end
    end
    readyIn = 1'b1;
    missIn  = 1'b0;
    chk("req_seen", seen, 1);
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, memDataValid, 0);
    chk({tag, "_accept"}, acceptWrite, 0);
    chk({tag, "_ramWrite"}, ramWrite, 0);
    chk({tag, "_ramAddr"}, ramAddr, 0);
    chk({tag, "_ramDataOut"}, ramDataOut, 0);
    chk({tag, "_memAddr"}, memAddr, 0);
    chk({tag, "_memDataOut"}, memDataOut, 0);
  endtask

  initial begin
    int           lat, w0;
    logic [27:0]  am;
    logic [31:0]  saddr;
    logic [127:0] wd;

    resetIn = 1'b0; readyIn = 1'b1; missIn = 1'b0; readWriteIn = 1'b0;
    missAddrIn = '0; writeBackIn = '0;
    idle_wait(3);
    check_zero_outputs("reset");
    resetIn = 1'b1;
    idle_wait(1);

    // Plain fill of block 1
    do_req(28'h00001, 1'b1, '0, 0, 0, -1, lat, am, saddr);
    chk("fill_lat", lat, 18);
    chk("fill_addr", am, 28'h00001);
    chk("fill_data", memDataOut, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    idle_wait(3);

    // Write-back of block 0xF02
    for (int k = 0; k < 16; k++) wd[8*k +: 8] = 8'(8'h30 + k);
    w0 = wr_cnt;
    do_req(28'h00F02, 1'b0, wd, 0, 0, -1, lat, am, saddr);
    chk("wb_accept_lat", lat, 1);
    chk("wb_accept_addr", am, 28'h00F02);
    idle_wait(20);
    chk("wb_write_cycles", wr_cnt - w0, 16);
    for (int k = 0; k < 16; k++) chk("wb_ram", env_byte(16'(16'hF020 + k)), 8'(8'h30 + k));

    // Write-back immediately followed by a held fill request
    for (int k = 0; k < 16; k++) wd[8*k +: 8] = 8'(8'h40 + k);
    w0 = wr_cnt;
    do_req(28'h00F03, 1'b0, wd, 0, 0, -1, lat, am, saddr);
    do_req(28'h00002, 1'b1, '0, 0, 0, -1, lat, am, saddr);
    chk("b2b_fill_lat", lat, 33);
    chk("b2b_fill_data", memDataOut, 128'h2F2E2D2C2B2A29282726252423222120);
    chk("b2b_write_cycles", wr_cnt - w0, 16);
    idle_wait(3);

    // Fill with a 5-cycle freeze while byte 7 is addressed
    do_req(28'h00001, 1'b1, '0, 8, 5, -1, lat, am, saddr);
    chk("stall_lat", lat, 23);
    chk("stall_addr", saddr, 32'h0000_0017);
    chk("stall_data", memDataOut, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    idle_wait(3);

    // Reset while write-back is on byte 9
    for (int k = 0; k < 16; k++) wd[8*k +: 8] = 8'(8'h60 + k);
    w0 = wr_cnt;
    do_req(28'h00F04, 1'b0, wd, 0, 0, -1, lat, am, saddr);
    repeat (8) @(posedge clkIn);
    #2;
    resetIn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    idle_wait(3);
    resetIn = 1'b1;
    idle_wait(2);
    chk("midreset_writes", wr_cnt - w0, 9);
    chk("midreset_ram8", env_byte(16'hF048), 8'h68);
    chk("midreset_ram9", env_byte(16'hF049), 8'h49);

    // Fill after reset
    do_req(28'h00003, 1'b1, '0, 0, 0, -1, lat, am, saddr);
    chk("post_reset_lat", lat, 18);
    chk("post_reset_data", memDataOut, 128'h3F3E3D3C3B3A39383736353433323130);
    idle_wait(3);

    // Request inputs change while a fill is running
    do_req(28'h00005, 1'b1, '0, 0, 0, 4, lat, am, saddr);
    chk("busy_lat", lat, 18);
    chk("busy_addr", am, 28'h00005);
    chk("busy_data", memDataOut, 128'h5F5E5D5C5B5A59585756555453525150);
    idle_wait(5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
